// File: rtl/pram_pkg.sv
// Shared PRAM definitions: default widths, owner encoding and the decoder window value.
// Imported by the arbiter, its starvation sub-block and the address decoder.
package pram_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int PRAM_AW = 12;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] PRAM_WIN_HI = 2'b00;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_INST = 2'd1,
    SEL_DATA = 2'd2
  } gnt_sel_e;

endpackage

// File: rtl/pram_arbiter_if.sv
// Requester and PRAM signals of the arbiter; slave is the arbiter side, master the environment.
// req/payload held until gnt; responses return one cycle after the grant.
interface pram_arbiter_if #(
  parameter int ADDR_W  = pram_pkg::ADDR_W,
  parameter int DATA_W  = pram_pkg::DATA_W,
  parameter int PRAM_AW = pram_pkg::PRAM_AW
) ();

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  pram_en;
  logic                  pram_we;
  logic [DATA_W/8-1:0]   pram_be;
  logic [PRAM_AW-1:0]    pram_addr;
  logic [DATA_W-1:0]     pram_wdata;
  logic [DATA_W-1:0]     pram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, pram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output pram_en, pram_we, pram_be, pram_addr, pram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, pram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  pram_en, pram_we, pram_be, pram_addr, pram_wdata
  );

endinterface

// File: rtl/pram_arb_starve.sv
// Data-priority grant select with a starvation counter that forces a fetch grant after STARVE_MAX data wins.
// Select is combinational in the request cycle; scnt updates on the clock.
module pram_arb_starve
  import pram_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_req,
  input  logic     d_req,
  output gnt_sel_e sel
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] scnt;
  logic [3:0] scnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= 4'd0;
    end else begin
      scnt <= scnt_nxt;
    end
  end

  // scnt only survives a cycle where fetch waits and data wins; everything else clears it.
  always_comb begin
    sel      = SEL_NONE;
    scnt_nxt = 4'd0;
    if (i_req && d_req) begin
      if (scnt < SMAX) begin
        sel      = SEL_DATA;
        scnt_nxt = scnt + 4'd1;
      end else begin
        sel      = SEL_INST;
      end
    end else if (d_req) begin
      sel = SEL_DATA;
    end else if (i_req) begin
      sel = SEL_INST;
    end
  end

endmodule

// File: rtl/pram_arbiter.sv
// PRAM arbiter: fetch vs load/store, combinational grant, read data steered to owner one cycle later.
// Full throughput; losers hold req. `define PRAM_ARB_STATS_EN adds conflict_cnt/stats_clr.
module pram_arbiter
#(
  parameter int ADDR_W     = pram_pkg::ADDR_W,
  parameter int DATA_W     = pram_pkg::DATA_W,
  parameter int PRAM_AW    = pram_pkg::PRAM_AW,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  pram_arbiter_if.slave    bus
`ifdef PRAM_ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      conflict_cnt
`endif
);

  import pram_pkg::*;

  gnt_sel_e sel;
  logic     i_gnt_w;
  logic     d_gnt_w;
  logic     rsp_v;
  logic     rsp_owner;
  logic     rsp_wr;
  logic     addr_unused;

  pram_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .sel   (sel)
  );

  // Grants are forced low while rst is high even though sel is combinational.
  assign i_gnt_w = !rst && (sel == SEL_INST);
  assign d_gnt_w = !rst && (sel == SEL_DATA);

  assign addr_unused = ^{bus.i_addr[ADDR_W-1:PRAM_AW+2], bus.i_addr[1:0],
                         bus.d_addr[ADDR_W-1:PRAM_AW+2], bus.d_addr[1:0]};

  always_comb begin
    bus.i_gnt      = i_gnt_w;
    bus.d_gnt      = d_gnt_w;
    bus.pram_en    = i_gnt_w | d_gnt_w;
    bus.pram_we    = d_gnt_w & bus.d_we;
    bus.pram_be    = '0;
    bus.pram_addr  = '0;
    bus.pram_wdata = '0;
    if (!rst) begin
      bus.pram_be = (d_gnt_w && bus.d_we) ? bus.d_be : '1;
    end
    if (i_gnt_w) begin
      bus.pram_addr  = bus.i_addr[PRAM_AW+1:2];
    end else if (d_gnt_w) begin
      bus.pram_addr  = bus.d_addr[PRAM_AW+1:2];
      bus.pram_wdata = bus.d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_v     <= 1'b0;
      rsp_owner <= OWN_INST;
      rsp_wr    <= 1'b0;
    end else begin
      rsp_v <= i_gnt_w | d_gnt_w;
      if (i_gnt_w | d_gnt_w) begin
        rsp_owner <= d_gnt_w ? OWN_DATA : OWN_INST;
        rsp_wr    <= d_gnt_w & bus.d_we;
      end
    end
  end

  // A write acknowledge returns zero data even though the PRAM read port is live.
  always_comb begin
    bus.i_rvalid = rsp_v && (rsp_owner == OWN_INST);
    bus.d_rvalid = rsp_v && (rsp_owner == OWN_DATA);
    bus.i_rdata  = bus.i_rvalid ? bus.pram_rdata : '0;
    bus.d_rdata  = (bus.d_rvalid && !rsp_wr) ? bus.pram_rdata : '0;
  end

`ifdef PRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if (stats_clr) begin
      conflict_cnt <= 16'd0;
    end else if (bus.i_req && bus.d_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pram_arbiter.sv
// Bench for pram_arbiter: directed vector table, starvation/reset sequences, then random traffic
// checked against a transaction-level model of grant order and response steering.
module tb_pram_arbiter;
  import pram_pkg::*;

  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pram_arbiter_if bus ();

`ifdef PRAM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] conflict_cnt;
`endif

  pram_arbiter #(.STARVE_MAX(SM)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef PRAM_ARB_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .conflict_cnt (conflict_cnt)
`endif
  );

  typedef struct packed {
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] prdata;
  } stim_t;

  typedef struct packed {
    logic        i_gnt;
    logic        d_gnt;
    logic        pram_en;
    logic        pram_we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } vec_t;

  int   vecs = 0;
  int   errs = 0;
  vec_t tbl[8];

  function automatic stim_t st(logic ir, logic [15:0] ia, logic dr, logic dw, logic [3:0] be,
                               logic [15:0] da, logic [31:0] wd, logic [31:0] pr);
    stim_t s;
    s.i_req = ir; s.i_addr = ia; s.d_req = dr; s.d_we = dw; s.d_be = be;
    s.d_addr = da; s.d_wdata = wd; s.prdata = pr;
    return s;
  endfunction

  function automatic obs_t mk(logic ig, logic dg, logic we, logic [3:0] be, logic [11:0] a,
                              logic [31:0] wd, logic irv, logic [31:0] ird, logic drv,
                              logic [31:0] drd);
    obs_t o;
    o.i_gnt = ig; o.d_gnt = dg; o.pram_en = ig | dg; o.pram_we = we; o.be = be;
    o.addr = a; o.wdata = wd; o.i_rvalid = irv; o.i_rdata = ird;
    o.d_rvalid = drv; o.d_rdata = drd;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.i_gnt = bus.i_gnt; o.d_gnt = bus.d_gnt; o.pram_en = bus.pram_en; o.pram_we = bus.pram_we;
    o.be = bus.pram_be; o.addr = bus.pram_addr; o.wdata = bus.pram_wdata;
    o.i_rvalid = bus.i_rvalid; o.i_rdata = bus.i_rdata;
    o.d_rvalid = bus.d_rvalid; o.d_rdata = bus.d_rdata;
    return o;
  endfunction

  task automatic drive(stim_t s);
    bus.i_req = s.i_req; bus.i_addr = s.i_addr; bus.d_req = s.d_req; bus.d_we = s.d_we;
    bus.d_be = s.d_be; bus.d_addr = s.d_addr; bus.d_wdata = s.d_wdata; bus.pram_rdata = s.prdata;
  endtask

  task automatic check(string name, obs_t exp);
    obs_t act;
    act = sample();
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef PRAM_ARB_STATS_EN
  task automatic check16(string name, logic [15:0] exp);
    vecs++;
    if (conflict_cnt !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, conflict_cnt, exp);
    end
  endtask
`endif

  // Random-phase model state: requester holds, fetch wait streak, previous grant kind.
  int          consec;
  int          prev;   // 0 none, 1 fetch, 2 data read, 3 data write
  logic        i_p, d_p, d_we_r;
  logic [15:0] i_a, d_a;
  logic [3:0]  d_be_r;
  logic [31:0] d_wd, prd;
  logic        gi, gd;
  obs_t        e;

  initial begin
    tbl[0] = '{st(1, 16'h0010, 0, 0, 4'h0, 16'h0000, 32'h0, 32'h0),
               mk(1, 0, 0, 4'hF, 12'h004, 32'h0, 0, 32'h0, 0, 32'h0)};
    tbl[1] = '{st(0, 16'h0000, 1, 1, 4'b0011, 16'h0020, 32'h12345678, 32'hDEADBEEF),
               mk(0, 1, 1, 4'h3, 12'h008, 32'h12345678, 1, 32'hDEADBEEF, 0, 32'h0)};
    tbl[2] = '{st(0, 16'h0000, 1, 0, 4'h0, 16'h0104, 32'h0, 32'h55555555),
               mk(0, 1, 0, 4'hF, 12'h041, 32'h0, 0, 32'h0, 1, 32'h0)};
    tbl[3] = '{st(1, 16'h0208, 0, 0, 4'h0, 16'h0000, 32'h0, 32'hA1A1A1A1),
               mk(1, 0, 0, 4'hF, 12'h082, 32'h0, 0, 32'h0, 1, 32'hA1A1A1A1)};
    tbl[4] = '{st(0, 16'h0000, 1, 0, 4'h0, 16'hC00C, 32'h0, 32'hB2B2B2B2),
               mk(0, 1, 0, 4'hF, 12'h003, 32'h0, 1, 32'hB2B2B2B2, 0, 32'h0)};
    tbl[5] = '{st(1, 16'h3FFF, 0, 0, 4'h0, 16'h0000, 32'h0, 32'hC3C3C3C3),
               mk(1, 0, 0, 4'hF, 12'hFFF, 32'h0, 0, 32'h0, 1, 32'hC3C3C3C3)};
    tbl[6] = '{st(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0, 32'hD4D4D4D4),
               mk(0, 0, 0, 4'hF, 12'h000, 32'h0, 1, 32'hD4D4D4D4, 0, 32'h0)};
    tbl[7] = '{st(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0, 32'hE5E5E5E5),
               mk(0, 0, 0, 4'hF, 12'h000, 32'h0, 0, 32'h0, 0, 32'h0)};

    // Reset with both requests high: everything must stay low.
    rst = 1'b1;
`ifdef PRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    drive(st(1, 16'h0010, 1, 1, 4'hF, 16'h0020, 32'hFFFFFFFF, 32'hFFFFFFFF));
    @(negedge clk);
    @(negedge clk);
    check("reset_state", '0);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].s);
      @(negedge clk);
      check($sformatf("table[%0d]", i), tbl[i].e);
      @(posedge clk); #1;
    end

    // Both requests held: four data grants, then one fetch grant, repeating.
    for (int k = 0; k < 15; k++) begin
      logic [31:0] pr;
      logic        pk_i, pk_d;
      pr   = 32'h100 + 32'(k);
      pk_i = (k > 0) && ((k - 1) % 5 == 4);
      pk_d = (k > 0) && !pk_i;
      drive(st(1, 16'h0040, 1, 0, 4'h0, 16'h0080, 32'h0, pr));
      @(negedge clk);
      if (k % 5 == 4)
        check($sformatf("starve[%0d]", k),
              mk(1, 0, 0, 4'hF, 12'h010, 32'h0, pk_i, pk_i ? pr : 32'h0, pk_d, pk_d ? pr : 32'h0));
      else
        check($sformatf("starve[%0d]", k),
              mk(0, 1, 0, 4'hF, 12'h020, 32'h0, pk_i, pk_i ? pr : 32'h0, pk_d, pk_d ? pr : 32'h0));
      @(posedge clk); #1;
    end

    // Data read granted, then reset before its response cycle.
    drive(st(0, 16'h0000, 1, 0, 4'h0, 16'h0084, 32'h0, 32'h77));
    @(negedge clk);
    check("rst_pre_grant", mk(0, 1, 0, 4'hF, 12'h021, 32'h0, 1, 32'h77, 0, 32'h0));
    #1 rst = 1'b1;
    #1 check("rst_async", '0);
    drive(st(1, 16'h0100, 1, 0, 4'h0, 16'h0084, 32'hFFFFFFFF, 32'hFFFFFFFF));
    @(negedge clk);
    check("rst_hold1", '0);
    @(negedge clk);
    check("rst_hold2", '0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(st(1, 16'h0100, 0, 0, 4'h0, 16'h0000, 32'h0, 32'h99));
    @(negedge clk);
    check("rst_first_gnt", mk(1, 0, 0, 4'hF, 12'h040, 32'h0, 0, 32'h0, 0, 32'h0));
    @(posedge clk); #1;
    drive(st(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0, 32'hABCD0123));
    @(negedge clk);
    check("rst_first_rsp", mk(0, 0, 0, 4'hF, 12'h000, 32'h0, 1, 32'hABCD0123, 0, 32'h0));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_quiet", mk(0, 0, 0, 4'hF, 12'h000, 32'h0, 0, 32'h0, 0, 32'h0));

    // Random traffic against the model.
    consec = 0; prev = 0; i_p = 0; d_p = 0;
    i_a = '0; d_a = '0; d_we_r = 0; d_be_r = '0; d_wd = '0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (!i_p && $urandom_range(0, 99) < 55) begin
        i_p = 1; i_a = 16'($urandom);
      end
      if (!d_p && $urandom_range(0, 99) < 55) begin
        d_p = 1; d_a = 16'($urandom); d_we_r = 1'($urandom); d_be_r = 4'($urandom);
        d_wd = $urandom;
      end
      prd = $urandom;
      drive(st(i_p, i_a, d_p, d_we_r, d_be_r, d_a, d_wd, prd));
      gi = 0; gd = 0;
      if (i_p && d_p) begin
        if (consec < SM) gd = 1; else gi = 1;
      end else if (d_p) gd = 1;
      else if (i_p) gi = 1;
      e = mk(gi, gd, gd && d_we_r, (gd && d_we_r) ? d_be_r : 4'hF,
             gi ? i_a[13:2] : (gd ? d_a[13:2] : 12'h0), gd ? d_wd : 32'h0,
             prev == 1, (prev == 1) ? prd : 32'h0, prev >= 2, (prev == 2) ? prd : 32'h0);
      @(negedge clk);
      check("random", e);
      if (!i_p || gi) consec = 0;
      else if (gd) consec++;
      prev = gi ? 1 : (gd ? (d_we_r ? 3 : 2) : 0);
      if (gi) i_p = 0;
      if (gd) d_p = 0;
    end

`ifdef PRAM_ARB_STATS_EN
    @(posedge clk); #1;
    drive(st(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0, 32'h0));
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    drive(st(1, 16'h0010, 1, 0, 4'h0, 16'h0020, 32'h0, 32'h0));
    for (int c = 0; c < 7; c++) @(posedge clk);
    #1 drive(st(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0, 32'h0));
    @(negedge clk);
    check16("conflict_cnt_7", 16'd7);
    @(posedge clk); #1;
    drive(st(1, 16'h0010, 1, 0, 4'h0, 16'h0020, 32'h0, 32'h0));
    stats_clr = 1'b1;
    @(negedge clk);
    check16("conflict_cnt_pre_clr", 16'd7);
    @(posedge clk); #1;
    stats_clr = 1'b0;
    drive(st(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0, 32'h0));
    @(negedge clk);
    check16("conflict_cnt_clr", 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
